// File: rtl/fp_pkg.sv
// Shared fp32 constants, FSM encoding and operand classification
// for the iterative divider.
package fp_pkg;

   localparam int unsigned EXP_W   = 8;
   localparam int unsigned MAN_W   = 23;
   localparam int unsigned BIAS    = 127;
   localparam int unsigned EXP_MAX = 255;
   localparam logic [31:0] QNAN    = 32'h7FC0_0000;

   typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

   typedef struct packed {
      logic is_zero;
      logic is_inf;
      logic is_nan;
   } fp_class_t;

   // Denormals (exponent field 0) classify as zero.
   function automatic fp_class_t classify(input logic [EXP_W+MAN_W-1:0] x);
      fp_class_t c;
      c.is_zero = (x[MAN_W +: EXP_W] == '0);
      c.is_inf  = (x[MAN_W +: EXP_W] == EXP_W'(EXP_MAX)) && (x[MAN_W-1:0] == '0);
      c.is_nan  = (x[MAN_W +: EXP_W] == EXP_W'(EXP_MAX)) && (x[MAN_W-1:0] != '0);
      return c;
   endfunction

endpackage

// File: rtl/fp_mant_div.sv
// Restoring mantissa divider: one quotient bit per step, MAN_W+3 steps
// producing the integer bit, MAN_W fraction bits, guard and spare bit.
module fp_mant_div #(
   parameter int unsigned MAN_W = 23
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               start,
   input  logic               step,
   input  logic [MAN_W-1:0]   fa,
   input  logic [MAN_W-1:0]   fb,
   output logic               done,
   output logic [MAN_W+2:0]   q,
   output logic               rem_nz
);

   localparam int unsigned RW = MAN_W + 2;
   localparam int unsigned QW = MAN_W + 3;
   localparam int unsigned CW = $clog2(QW);

   logic [RW-1:0] r;
   logic [RW-1:0] d;
   logic [RW-1:0] r_sub;
   logic [CW-1:0] cnt;
   logic          ge;

   assign ge     = (r >= d);
   assign r_sub  = ge ? (r - d) : r;
   assign done   = (cnt == CW'(QW - 1));
   assign rem_nz = |r;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r   <= '0;
         d   <= '0;
         q   <= '0;
         cnt <= '0;
      end else if (start) begin
         r   <= {2'b01, fa};
         d   <= {2'b01, fb};
         q   <= '0;
         cnt <= '0;
      end else if (step) begin
         // Partial remainder stays below 2*d, so the shifted value fits RW bits.
         r <= RW'({r_sub, 1'b0});
         q <= {q[QW-2:0], ge};
         if (!done) begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/fp_divide_iter.sv
// Iterative fp32 divider c = a / b behind valid/ready handshakes;
// round-to-nearest-even, denormals flushed to zero on input and output.
module fp_divide_iter #(
   parameter int unsigned EXP_W = fp_pkg::EXP_W,
   parameter int unsigned MAN_W = fp_pkg::MAN_W
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   valid_i,
   output logic                   ready_o,
   input  logic [EXP_W+MAN_W:0]   a_i,
   input  logic [EXP_W+MAN_W:0]   b_i,
   output logic                   valid_o,
   input  logic                   ready_i,
   output logic [EXP_W+MAN_W:0]   c_o
);

   import fp_pkg::*;

   localparam int unsigned DW  = EXP_W + MAN_W + 1;
   localparam int unsigned XW  = EXP_W + 2;
   localparam int unsigned QW  = MAN_W + 3;
   localparam int unsigned MW1 = MAN_W + 1;

   state_t                 state, state_d;
   logic                   sign, sign_d;
   logic signed [XW-1:0]   exp_q, exp_d;
   logic [DW-1:0]          res_q, res_d;
   logic [DW-1:0]          c_d;
   logic                   valid_d, ready_d;
   logic                   start, step, div_done, rem_nz;
   logic [QW-1:0]          q;
   fp_class_t              ca, cb;
   logic                   sp_nan, sp_inf, sp_zero;

   logic [MAN_W-1:0]       man_n;
   logic [MAN_W:0]         man_r;
   logic                   g, s, inc;
   logic signed [XW-1:0]   exp_n, exp_r;
   logic [DW-1:0]          rnd;

   fp_mant_div #(.MAN_W(MAN_W)) u_mant_div (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .start  (start),
      .step   (step),
      .fa     (a_i[MAN_W-1:0]),
      .fb     (b_i[MAN_W-1:0]),
      .done   (div_done),
      .q      (q),
      .rem_nz (rem_nz)
   );

   assign ca      = classify(a_i[DW-2:0]);
   assign cb      = classify(b_i[DW-2:0]);
   assign sp_nan  = ca.is_nan | cb.is_nan | (ca.is_zero & cb.is_zero) | (ca.is_inf & cb.is_inf);
   assign sp_inf  = ca.is_inf | cb.is_zero;
   assign sp_zero = ca.is_zero | cb.is_inf;

   // Normalize the quotient, round to nearest even, then clamp the exponent.
   always_comb begin
      if (q[QW-1]) begin
         man_n = q[QW-2:2];
         g     = q[1];
         s     = q[0] | rem_nz;
         exp_n = exp_q;
      end else begin
         man_n = q[QW-3:1];
         g     = q[0];
         s     = rem_nz;
         exp_n = exp_q - XW'(1);
      end
      inc   = g & (s | man_n[0]);
      man_r = {1'b0, man_n} + MW1'(inc);
      exp_r = man_r[MAN_W] ? (exp_n + XW'(1)) : exp_n;
      if (exp_r >= $signed(XW'(EXP_MAX))) begin
         rnd = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (exp_r[XW-1] || (exp_r == '0)) begin
         rnd = {sign, {(DW-1){1'b0}}};
      end else begin
         rnd = {sign, exp_r[EXP_W-1:0], man_r[MAN_W-1:0]};
      end
   end

   always_comb begin
      state_d = state;
      sign_d  = sign;
      exp_d   = exp_q;
      res_d   = res_q;
      valid_d = valid_o;
      ready_d = ready_o;
      c_d     = c_o;
      start   = 1'b0;
      step    = 1'b0;
      case (state)
         IDLE: begin
            ready_d = 1'b1;
            if (valid_i && ready_o) begin
               start   = 1'b1;
               ready_d = 1'b0;
               sign_d  = a_i[DW-1] ^ b_i[DW-1];
               exp_d   = $signed(XW'(a_i[MAN_W +: EXP_W])) - $signed(XW'(b_i[MAN_W +: EXP_W]))
                       + $signed(XW'(BIAS));
               if (sp_nan) begin
                  res_d   = DW'(QNAN);
                  state_d = DONE;
               end else if (sp_inf) begin
                  res_d   = {sign_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                  state_d = DONE;
               end else if (sp_zero) begin
                  res_d   = {sign_d, {(DW-1){1'b0}}};
                  state_d = DONE;
               end else begin
                  state_d = DIV;
               end
            end
         end
         DIV: begin
            step = 1'b1;
            if (div_done) begin
               state_d = ROUND;
            end
         end
         ROUND: begin
            res_d   = rnd;
            state_d = DONE;
         end
         DONE: begin
            // First DONE cycle publishes the result; it is then held until taken.
            if (!valid_o) begin
               valid_d = 1'b1;
               c_d     = res_q;
            end else if (ready_i) begin
               valid_d = 1'b0;
               ready_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state   <= IDLE;
         sign    <= 1'b0;
         exp_q   <= '0;
         res_q   <= '0;
         valid_o <= 1'b0;
         ready_o <= 1'b1;
         c_o     <= '0;
      end else begin
         state   <= state_d;
         sign    <= sign_d;
         exp_q   <= exp_d;
         res_q   <= res_d;
         valid_o <= valid_d;
         ready_o <= ready_d;
         c_o     <= c_d;
      end
   end

endmodule

// File: tb/tb_fp_divide_iter.sv
// Directed scoreboard bench for fp_divide_iter: arithmetic, specials,
// range limits, back-pressure and mid-operation reset.
module tb_fp_divide_iter;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        valid_i;
   logic        ready_o;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] c_o;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [31:0] sb[$];

   always #5 clk = ~clk;

   fp_divide_iter dut (
      .clk_i   (clk),
      .rst_ni  (rst_ni),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .a_i     (a_i),
      .b_i     (b_i),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .c_o     (c_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present operands until accepted; leaves time at accept edge + 1.
   task automatic send(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv, input string tag);
      int w;
      w = 0;
      @(negedge clk);
      valid_i = 1'b1;
      a_i     = a;
      b_i     = b;
      while (!ready_o && w < 100) begin
         @(negedge clk);
         w++;
      end
      check({tag, " accept"}, 32'(ready_o), 32'd1);
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      sb.push_back(expv);
   endtask

   task automatic get_result(input string tag, input int exp_lat);
      int          lat;
      logic [31:0] e;
      lat = 0;
      while (!valid_o && lat < 60) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      e = 32'hDEAD_BEEF;
      if (sb.size() > 0) e = sb.pop_front();
      check({tag, " c_o"}, c_o, e);
   endtask

   task automatic release_result(input string tag);
      @(posedge clk);
      #1;
      check({tag, " valid_o after release"}, 32'(valid_o), 32'd0);
      check({tag, " ready_o after release"}, 32'(ready_o), 32'd1);
   endtask

   task automatic run(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] expv, input int lat, input string tag);
      send(a, b, expv, tag);
      get_result(tag, lat);
      release_result(tag);
   endtask

   initial begin
      int seen;
      rst_ni  = 1'b0;
      valid_i = 1'b0;
      ready_i = 1'b1;
      a_i     = '0;
      b_i     = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset valid_o", 32'(valid_o), 32'd0);
      check("reset ready_o", 32'(ready_o), 32'd1);
      check("reset c_o", c_o, 32'h0);
      rst_ni = 1'b1;

      // Normal arithmetic
      run(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 28, "6/2");
      run(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 28, "1/3");
      run(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 28, "1/1");
      run(32'h4120_0000, 32'h4080_0000, 32'h4020_0000, 28, "10/4");
      run(32'hC0E0_0000, 32'h4000_0000, 32'hC060_0000, 28, "-7/2");
      run(32'h4000_0000, 32'h4040_0000, 32'h3F2A_AAAB, 28, "2/3");

      // Special operands
      run(32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1, "-1/0");
      run(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1, "0/0");
      run(32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 1, "inf/inf");
      run(32'h3F80_0000, 32'hFF80_0000, 32'h8000_0000, 1, "1/-inf");
      run(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1, "nan/1");
      run(32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 1, "denorm/1");

      // Range limits
      run(32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 28, "overflow");
      run(32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 28, "underflow");

      // Back-pressure with a second request waiting
      ready_i = 1'b0;
      send(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, "bp1");
      get_result("bp1", 28);
      valid_i = 1'b1;
      a_i     = 32'h3F80_0000;
      b_i     = 32'h4040_0000;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("bp hold c_o", c_o, 32'h4040_0000);
         check("bp hold valid_o", 32'(valid_o), 32'd1);
         check("bp hold ready_o", 32'(ready_o), 32'd0);
      end
      @(negedge clk);
      ready_i = 1'b1;
      release_result("bp1");
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      sb.push_back(32'h3EAA_AAAB);
      get_result("bp2", 28);
      release_result("bp2");

      // Reset during DIV cycle 10
      send(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, "rst");
      repeat (10) @(posedge clk);
      #1;
      rst_ni = 1'b0;
      @(posedge clk);
      #1;
      check("midrst valid_o", 32'(valid_o), 32'd0);
      check("midrst ready_o", 32'(ready_o), 32'd1);
      check("midrst c_o", c_o, 32'h0);
      rst_ni = 1'b1;
      void'(sb.pop_back());
      seen = 0;
      repeat (35) begin
         @(posedge clk);
         #1;
         if (valid_o) seen++;
      end
      check("midrst no output", 32'(seen), 32'd0);
      run(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 28, "6/2 after reset");

      check("scoreboard empty", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
